// File: rtl/regs_wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: requester indices, register
// count, default widths, and the round-robin pointer width helper.
package regs_wb_arbiter_pkg;

    localparam int WB_ALU      = 0;
    localparam int WB_LSU      = 1;
    localparam int WB_MDU      = 2;

    localparam int NUM_REQ_DEF = 3;
    localparam int REG_NUM     = 32;
    localparam int XLEN        = 32;
    localparam int AW_DEF      = 5;

    // Width of a pointer that selects one of n requesters; never zero.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regs_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps, and the
// pointer advances past the granted requester (holds when nothing is granted).
module wba_rr_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PW      = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      nxt_ptr
);

    logic found;

    always_comb begin
        gnt     = '0;
        nxt_ptr = ptr;
        found   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int idx;
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt_ptr  = (idx + 1 == NUM_REQ) ? '0 : PW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-file writeback arbiter with busy scoreboard for hazard stalls.
// Optional conflict-cycle counter enabled by defining WBA_PERF_CNT_EN.
module regs_wb_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int XLEN    = regs_wb_arbiter_pkg::XLEN,
    parameter int AW      = AW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      WB_valid,
    output logic [NUM_REQ-1:0]      WB_ready,
    input  logic [NUM_REQ*AW-1:0]   WB_addr,
    input  logic [NUM_REQ*XLEN-1:0] WB_data,
    input  logic                    SB_set,
    input  logic [AW-1:0]           SB_setaddr,
    input  logic [AW-1:0]           SB_qaddr1,
    input  logic [AW-1:0]           SB_qaddr2,
    output logic                    SB_stall,
    output logic                    REGS_wen,
    output logic [AW-1:0]           REGS_wraddr,
    output logic [XLEN-1:0]         REGS_wrdata
`ifdef WBA_PERF_CNT_EN
    ,
    output logic [31:0]             WBA_conflict_cnt
`endif
);

    localparam int PW = ptr_w(NUM_REQ);

    logic [PW-1:0]      ptr_q, ptr_d, nxt_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic               any_gnt;
    logic [AW-1:0]      gnt_addr;
    logic [XLEN-1:0]    gnt_data;

    logic               wen_q, wen_d;
    logic [AW-1:0]      wraddr_q, wraddr_d;
    logic [XLEN-1:0]    wrdata_q, wrdata_d;
    logic [REG_NUM-1:0] busy_q, busy_d;

    wba_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .req     (WB_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .nxt_ptr (nxt_ptr)
    );

    assign WB_ready = gnt;
    assign any_gnt  = |gnt;

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_addr = WB_addr[i*AW +: AW];
                gnt_data = WB_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes are consumed by the grant but never reach the register file.
    always_comb begin
        ptr_d    = nxt_ptr;
        wen_d    = any_gnt && (gnt_addr != '0);
        wraddr_d = any_gnt ? gnt_addr : wraddr_q;
        wrdata_d = any_gnt ? gnt_data : wrdata_q;
    end

    // Clear on the write's registration edge; a same-edge set wins because a
    // newer producer has just been issued to that register.
    always_comb begin
        busy_d = busy_q;
        if (any_gnt) begin
            busy_d[gnt_addr] = 1'b0;
        end
        if (SB_set && (SB_setaddr != '0)) begin
            busy_d[SB_setaddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign SB_stall = busy_q[SB_qaddr1] | busy_q[SB_qaddr2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            wen_q    <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            busy_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wen_q    <= wen_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            busy_q   <= busy_d;
        end
    end

    assign REGS_wen    = wen_q;
    assign REGS_wraddr = wraddr_q;
    assign REGS_wrdata = wrdata_q;

`ifdef WBA_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (($countones(WB_valid) >= 2) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign WBA_conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench for regs_wb_arbiter: directed scenarios plus randomized
// traffic against a behavioural model; covers WBA_PERF_CNT_EN when defined.
module tb_regs_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  WB_valid;
    logic [2:0]  WB_ready;
    logic [14:0] WB_addr;
    logic [95:0] WB_data;
    logic        SB_set;
    logic [4:0]  SB_setaddr, SB_qaddr1, SB_qaddr2;
    logic        SB_stall;
    logic        REGS_wen;
    logic [4:0]  REGS_wraddr;
    logic [31:0] REGS_wrdata;
`ifdef WBA_PERF_CNT_EN
    logic [31:0] WBA_conflict_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // behavioural model state
    int          m_ptr;
    bit [31:0]   m_busy;
    bit          m_wen;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    longint      m_cnt;
    logic [2:0]  exp_ready;
    logic        exp_stall;

    always #5 clk = ~clk;

    regs_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .WB_valid    (WB_valid),
        .WB_ready    (WB_ready),
        .WB_addr     (WB_addr),
        .WB_data     (WB_data),
        .SB_set      (SB_set),
        .SB_setaddr  (SB_setaddr),
        .SB_qaddr1   (SB_qaddr1),
        .SB_qaddr2   (SB_qaddr2),
        .SB_stall    (SB_stall),
        .REGS_wen    (REGS_wen),
        .REGS_wraddr (REGS_wraddr),
        .REGS_wrdata (REGS_wrdata)
`ifdef WBA_PERF_CNT_EN
        ,
        .WBA_conflict_cnt (WBA_conflict_cnt)
`endif
    );

    // First valid requester found going round from the pointer, or -1.
    function automatic int model_grant(input logic [2:0] v, input int p);
        for (int k = 0; k < 3; k++) begin
            if (v[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_busy = '0; m_wen = 0; m_addr = '0; m_data = '0; m_cnt = 0;
    endtask

    task automatic idle_inputs();
        WB_valid = '0; WB_addr = '0; WB_data = '0;
        SB_set = 0; SB_setaddr = '0; SB_qaddr1 = '0; SB_qaddr2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Let combinational outputs settle and predict them from the model.
    task automatic settle();
        int g;
        #1;
        g = model_grant(WB_valid, m_ptr);
        exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
        exp_stall = m_busy[SB_qaddr1] | m_busy[SB_qaddr2];
    endtask

    // Advance the model by one clock using the current inputs, then the DUT.
    task automatic edge_step();
        int g;
        g = model_grant(WB_valid, m_ptr);
        if (g >= 0) begin
            m_wen  = (WB_addr[g*5 +: 5] != 0);
            m_addr = WB_addr[g*5 +: 5];
            m_data = WB_data[g*32 +: 32];
            m_ptr  = (g + 1) % 3;
            m_busy[m_addr] = 0;
        end else begin
            m_wen = 0;
        end
        if (SB_set && SB_setaddr != 0) m_busy[SB_setaddr] = 1;
        m_busy[0] = 0;
        if ($countones(WB_valid) >= 2 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #3;
        checks++;
        if (REGS_wen !== 1'b0 || REGS_wraddr !== 5'd0 || REGS_wrdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: got wen=%b addr=%0d data=%h, want 0/0/0",
                     REGS_wen, REGS_wraddr, REGS_wrdata);
        end
        do_reset();
        SB_qaddr1 = 5'd7; SB_qaddr2 = 5'd31;
        settle();
        checks++;
        if (SB_stall !== 1'b0 || WB_ready !== 3'b000) begin
            failures++;
            $display("FAIL reset_sb_ready: got stall=%b ready=%b, want 0/000", SB_stall, WB_ready);
        end
    endtask

    task automatic test_single_alu();
        do_reset();
        WB_valid = 3'b001; WB_addr[4:0] = 5'd5; WB_data[31:0] = 32'hDEADBEEF;
        settle();
        checks++;
        if (WB_ready !== 3'b001) begin
            failures++;
            $display("FAIL alu_ready: got %b want 001", WB_ready);
        end
        edge_step();
        WB_valid = 3'b000; WB_data[31:0] = 32'h0;
        checks++;
        if (REGS_wen !== 1'b1 || REGS_wraddr !== 5'd5 || REGS_wrdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL alu_write: got wen=%b addr=%0d data=%h want 1/5/deadbeef",
                     REGS_wen, REGS_wraddr, REGS_wrdata);
        end
        settle();
        edge_step();
        checks++;
        if (REGS_wen !== 1'b0 || REGS_wraddr !== 5'd5 || REGS_wrdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL idle_hold: got wen=%b addr=%0d data=%h want 0/5/deadbeef",
                     REGS_wen, REGS_wraddr, REGS_wrdata);
        end
    endtask

    task automatic test_all_three();
        logic [31:0] d [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            WB_addr[i*5 +: 5]   = 5'(i + 1);
            WB_data[i*32 +: 32] = d[i];
        end
        WB_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (WB_ready !== 3'(1 << i)) begin
                failures++;
                $display("FAIL rr_order[%0d]: got ready=%b want %b", i, WB_ready, 3'(1 << i));
            end
            edge_step();
            WB_valid[i] = 1'b0;
            checks++;
            if (REGS_wen !== 1'b1 || REGS_wraddr !== 5'(i + 1) || REGS_wrdata !== d[i]) begin
                failures++;
                $display("FAIL rr_write[%0d]: got wen=%b addr=%0d data=%h want 1/%0d/%h",
                         i, REGS_wen, REGS_wraddr, REGS_wrdata, i + 1, d[i]);
            end
        end
    endtask

    task automatic test_scoreboard_stall();
        do_reset();
        SB_set = 1; SB_setaddr = 5'd7;
        settle();
        edge_step();
        SB_set = 0; SB_qaddr1 = 5'd7; SB_qaddr2 = 5'd3;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (SB_stall !== 1'b1) begin
                failures++;
                $display("FAIL sb_busy_wait[%0d]: got stall=%b want 1", i, SB_stall);
            end
            edge_step();
        end
        WB_valid = 3'b100; WB_addr[14:10] = 5'd7; WB_data[95:64] = 32'hCAFE0007;
        settle();
        checks++;
        if (WB_ready !== 3'b100 || SB_stall !== 1'b1) begin
            failures++;
            $display("FAIL sb_mdu_grant: got ready=%b stall=%b want 100/1", WB_ready, SB_stall);
        end
        edge_step();
        WB_valid = 3'b000;
        #1;
        checks++;
        if (REGS_wen !== 1'b1 || REGS_wraddr !== 5'd7 || SB_stall !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear: got wen=%b addr=%0d stall=%b want 1/7/0",
                     REGS_wen, REGS_wraddr, SB_stall);
        end
    endtask

    task automatic test_same_edge_set();
        do_reset();
        SB_set = 1; SB_setaddr = 5'd9; SB_qaddr1 = 5'd9;
        settle();
        edge_step();
        WB_valid = 3'b010; WB_addr[9:5] = 5'd9; WB_data[63:32] = 32'h0000_0009;
        settle();
        edge_step();
        SB_set = 0; WB_valid = 3'b000;
        settle();
        checks++;
        if (REGS_wen !== 1'b1 || SB_stall !== 1'b1) begin
            failures++;
            $display("FAIL same_edge_set_wins: got wen=%b stall=%b want 1/1", REGS_wen, SB_stall);
        end
        WB_valid = 3'b010;
        settle();
        edge_step();
        WB_valid = 3'b000;
        settle();
        checks++;
        if (SB_stall !== 1'b0) begin
            failures++;
            $display("FAIL later_write_clears: got stall=%b want 0", SB_stall);
        end
    endtask

    task automatic test_x0();
        do_reset();
        WB_valid = 3'b010; WB_addr[9:5] = 5'd0; WB_data[63:32] = 32'h0000_1234;
        SB_set = 1; SB_setaddr = 5'd0; SB_qaddr1 = 5'd0; SB_qaddr2 = 5'd0;
        settle();
        checks++;
        if (WB_ready !== 3'b010) begin
            failures++;
            $display("FAIL x0_ready: got %b want 010", WB_ready);
        end
        edge_step();
        WB_valid = 3'b000;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (REGS_wen !== 1'b0 || SB_stall !== 1'b0) begin
                failures++;
                $display("FAIL x0_no_write[%0d]: got wen=%b stall=%b want 0/0", i, REGS_wen, SB_stall);
            end
            edge_step();
        end
        SB_set = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        WB_valid = 3'b011;
        WB_addr[4:0] = 5'd12; WB_addr[9:5] = 5'd13;
        SB_set = 1; SB_setaddr = 5'd20; SB_qaddr1 = 5'd20;
        repeat (4) begin
            settle();
            edge_step();
        end
`ifdef WBA_PERF_CNT_EN
        checks++;
        if (WBA_conflict_cnt !== 32'd4) begin
            failures++;
            $display("FAIL perf_cnt: got %0d want 4", WBA_conflict_cnt);
        end
`endif
        #2 rst_n = 0;
        #1;
        checks++;
        if (REGS_wen !== 1'b0 || SB_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got wen=%b stall=%b want 0/0", REGS_wen, SB_stall);
        end
`ifdef WBA_PERF_CNT_EN
        checks++;
        if (WBA_conflict_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_cnt: got %0d want 0", WBA_conflict_cnt);
        end
`endif
        do_reset();
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            SB_set     = ($urandom_range(0, 3) == 0);
            SB_setaddr = 5'($urandom_range(0, 7));
            SB_qaddr1  = 5'($urandom_range(0, 7));
            SB_qaddr2  = 5'($urandom_range(0, 31));
            for (int i = 0; i < 3; i++) begin
                if (!WB_valid[i] && $urandom_range(0, 1) == 1) begin
                    WB_valid[i]         = 1'b1;
                    WB_addr[i*5 +: 5]   = 5'($urandom_range(0, 7));
                    WB_data[i*32 +: 32] = $urandom;
                end
            end
            settle();
            checks++;
            if (WB_ready !== exp_ready || SB_stall !== exp_stall) begin
                failures++;
                $display("FAIL rand_comb[%0d]: got ready=%b stall=%b want %b/%b",
                         c, WB_ready, SB_stall, exp_ready, exp_stall);
            end
            g = model_grant(WB_valid, m_ptr);
            edge_step();
            if (g >= 0) WB_valid[g] = 1'b0;
            checks++;
            if (REGS_wen !== m_wen || (m_wen && (REGS_wraddr !== m_addr || REGS_wrdata !== m_data))) begin
                failures++;
                $display("FAIL rand_out[%0d]: got wen=%b addr=%0d data=%h want %b/%0d/%h",
                         c, REGS_wen, REGS_wraddr, REGS_wrdata, m_wen, m_addr, m_data);
            end
`ifdef WBA_PERF_CNT_EN
            checks++;
            if (WBA_conflict_cnt !== 32'(m_cnt)) begin
                failures++;
                $display("FAIL rand_cnt[%0d]: got %0d want %0d", c, WBA_conflict_cnt, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_all_three();
        test_scoreboard_stall();
        test_same_edge_set();
        test_x0();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
